seq_left_shifter: RTL and testbench
===================================

Name: seq_left_shifter

Overview:
Iterative multi-cycle 16-bit left shifter for the SCRISC-16 datapath. It is the left-direction counterpart of the combinational right shifter and serves SHL/ROL operations where area matters more than latency. The ALU control starts it with a one-cycle start pulse. It shifts STEP bits per cycle and reports completion with a one-cycle done pulse plus a carry-out flag.

Parameters:
- WIDTH, 16, datapath width; fixed at 16 for SCRISC-16 and only checked, not generalised.
- STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- in  input  16  operand, sampled on an accepted start.
- sh  input  5  shift amount 0..31, sampled on an accepted start.
- rot  input  1  rotate select; port exists only with SHL_ROTATE_EN.
- out  output  16  result; holds until the next accepted start.
- carry  output  1  last bit shifted out of bit 15; 0 if sh==0.
- busy  output  1  high while in the SHIFT state.
- done  output  1  one-cycle pulse when out and carry are valid.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: rst_n low at a rising edge forces state=IDLE, out=0, carry=0, busy=0, done=0, count=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches in into the working register, cnt=effective amount n, clears carry.
  - n==0 -> DONE; otherwise -> SHIFT.
- SHIFT:
  - Each cycle shift by m=min(STEP,cnt); cnt-=m.
  - Logical: shift in zeros.
  - carry = last bit shifted out, i.e. bit (16-m) of the pre-step value.
  - cnt reaching 0 -> DONE.
- DONE: done=1 for exactly this cycle; out and carry are final; -> IDLE.
- Latency: done is high ceil(n/STEP)+1 cycles after the cycle start was sampled. For n==0 this is 1 cycle.
- Logical amounts of 16..31 are iterated in full (no early exit). Result is 0. Carry is 0 for n>16 and in[0] for n==16.
- start while busy or in DONE is ignored, with no queuing. in and sh may change freely after acceptance.
- out updates every SHIFT cycle (intermediate values are visible) and is only architecturally valid when done=1. It holds afterwards.
- busy=1 only in SHIFT.
- Reset mid-operation aborts immediately: no done pulse, outputs go to their reset values.
- start and rst_n low together: reset wins.

Optional Feature:
SHL_ROTATE_EN
- Defined:
  - rot port present.
  - rot=1 selects rotate-left: bits leaving bit 15 enter bit 0.
  - Effective amount n=sh[3:0], so sh=16 rotates by 0.
  - carry = last bit moved from bit 15 to bit 0, or 0 if n==0.
  - rot is latched with start.
- Undefined: no rot port; logical shift only; n=sh.

Decomposition:
- Package scrisc_shift_pkg:
  - WIDTH=16.
  - State enumeration IDLE/SHIFT/DONE.
  - SHAMT_W=5.
- Sub-module shl_step: combinational single-step shifter. Inputs are value, m (0..STEP) and rot. Outputs are the shifted value and the carry bit. It is instantiated once and feeds the working register.

Test Plan (STEP=1 unless noted):
- in=16'h8001, sh=1 -> out=16'h0002, carry=1, done at cycle 2 after start.
- in=16'h00FF, sh=4 -> out=16'h0FF0, carry=0, done at cycle 5. Rerun with STEP=4 -> done at cycle 2, same result.
- in=16'h1234, sh=0 -> out=16'h1234, carry=0, done at cycle 1. Also in=16'hFFFF, sh=20 -> out=0, carry=0, done at cycle 21.
- SHL_ROTATE_EN, rot=1, in=16'h8001, sh=17 -> out=16'h0003, carry=1, done at cycle 2. Also rot=1, sh=16 -> out=in, done at cycle 1.
- in=16'hABCD, sh=8 accepted; second start with in=16'h0001, sh=1 while busy -> ignored; out=16'hCD00, carry=1, only one done pulse.
- sh=10 accepted; rst_n=0 during SHIFT cycle 3 -> next cycle out=0, carry=0, busy=0, no done. A subsequent start works normally.

Source files
------------

// File: rtl/scrisc_shift_pkg.sv
// Shared definitions for the SCRISC-16 iterative shifter.
// Build option: SHL_ROTATE_EN adds the rotate-left mode to seq_left_shifter.
package scrisc_shift_pkg;

    // Datapath width of SCRISC-16; the shifter is not generalised beyond it.
    localparam int WIDTH   = 16;
    // Width of the requested shift amount (0..31).
    localparam int SHAMT_W = 5;
    // Width of a per-cycle step amount (0..4).
    localparam int STEP_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_left_shifter_shl_step.sv
// Combinational single-step left shifter/rotator used by seq_left_shifter.
// Shifts value_i left by m_i bits, either filling with zeros or wrapping the
// bits that leave bit 15 back into the low end. The carry is the last bit to
// leave bit 15, which is 0 when m_i is 0.
module shl_step
    import scrisc_shift_pkg::*;
(
    input  logic [WIDTH-1:0]  value_i,
    input  logic [STEP_W-1:0] m_i,
    input  logic              rot_i,
    output logic [WIDTH-1:0]  value_o,
    output logic              carry_o
);

    // Double-width copy: the upper half collects the bits pushed out of the top.
    logic [2*WIDTH-1:0] ext;

    // Shift once; rotate folds the spilled bits back in, carry is the lowest spilled bit.
    always_comb begin
        ext     = {{WIDTH{1'b0}}, value_i} << m_i;
        value_o = ext[WIDTH-1:0] | (rot_i ? ext[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}});
        carry_o = ext[WIDTH];
    end

endmodule

// File: rtl/seq_left_shifter.sv
// Iterative multi-cycle 16-bit left shifter for the SCRISC-16 datapath.
// A start pulse in IDLE captures the operand and amount; the working register
// is then shifted STEP bits per cycle until the amount is used up, after which
// a one-cycle done pulse marks out/carry as valid.
// Build option: SHL_ROTATE_EN adds the rot port and rotate-left mode, where
// the effective amount is sh[3:0].
module seq_left_shifter
    import scrisc_shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] sh,
`ifdef SHL_ROTATE_EN
    input  logic               rot,
`endif
    output logic [WIDTH-1:0]   out,
    output logic               carry,
    output logic               busy,
    output logic               done
);

    // Only a fixed 16-bit datapath and step sizes 1, 2 and 4 are supported.
    if (WIDTH != 16) begin : g_bad_width
        $error("seq_left_shifter: WIDTH must be 16");
    end
    if (STEP != 1 && STEP != 2 && STEP != 4) begin : g_bad_step
        $error("seq_left_shifter: STEP must be 1, 2 or 4");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   val_q,   val_d;
    logic               carry_q, carry_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic               rot_q,   rot_d;

    logic               rot_req;
    logic [SHAMT_W-1:0] n_req;
    logic [STEP_W-1:0]  m;
    logic [WIDTH-1:0]   step_val;
    logic               step_carry;

`ifdef SHL_ROTATE_EN
    // Effective amount of a request: rotates only use the low four bits.
    always_comb begin
        rot_req = rot;
        n_req   = rot ? {1'b0, sh[3:0]} : sh;
    end
`else
    // Effective amount of a request: logical shifts use the full amount.
    always_comb begin
        rot_req = 1'b0;
        n_req   = sh;
    end
`endif

    // Bits to move this cycle: a full step, or whatever remains if less.
    always_comb begin
        if (cnt_q >= SHAMT_W'(STEP)) begin
            m = STEP_W'(STEP);
        end else begin
            m = cnt_q[STEP_W-1:0];
        end
    end

    shl_step u_step (
        .value_i (val_q),
        .m_i     (m),
        .rot_i   (rot_q),
        .value_o (step_val),
        .carry_o (step_carry)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        val_d   = val_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = in;
                    cnt_d   = n_req;
                    carry_d = 1'b0;
                    rot_d   = rot_req;
                    state_d = (n_req == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                val_d   = step_val;
                carry_d = step_carry;
                cnt_d   = cnt_q - SHAMT_W'(m);
                if (cnt_q == SHAMT_W'(m)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and working registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
        end
    end

    assign out   = val_q;
    assign carry = carry_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter. Two instances run side by side
// (STEP=1 and STEP=4); expected results are queued when a start is driven and
// compared, including the completion cycle, when each done pulse appears.
// Build option: SHL_ROTATE_EN enables the rotate vectors and the rot port.
module tb_seq_left_shifter;

    typedef struct {
        logic [15:0] a;
        logic [4:0]  s;
        logic        r;
        logic [15:0] eo;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        carry;
        int          cyc;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] in_v   = '0;
    logic [4:0]  sh_v   = '0;
`ifdef SHL_ROTATE_EN
    logic        rot_v  = 1'b0;
`endif

    logic [15:0] out1, out4;
    logic        carry1, carry4, busy1, busy4, done1, done4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_left_shifter #(.STEP(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .in    (in_v),
        .sh    (sh_v),
`ifdef SHL_ROTATE_EN
        .rot   (rot_v),
`endif
        .out   (out1),
        .carry (carry1),
        .busy  (busy1),
        .done  (done1)
    );

    seq_left_shifter #(.STEP(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .in    (in_v),
        .sh    (sh_v),
`ifdef SHL_ROTATE_EN
        .rot   (rot_v),
`endif
        .out   (out4),
        .carry (carry4),
        .busy  (busy4),
        .done  (done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: logical left shift of a by n (0..31), result and last bit out.
    function automatic logic [16:0] model(input logic [15:0] a, input int n);
        logic [15:0] o;
        logic        c;
        o = (n >= 16) ? 16'h0000 : (a << n);
        c = (n == 0 || n > 16) ? 1'b0 : a[16-n];
        return {c, o};
    endfunction

    // Scoreboard for the STEP=1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            check("pending1", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("out1", 32'(out1), 32'(e1.out));
                check("carry1", 32'(carry1), 32'(e1.carry));
                check("lat1", cyc, e1.cyc);
            end
        end
    end

    // Scoreboard for the STEP=4 instance.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            check("pending4", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("out4", 32'(out4), 32'(e4.out));
                check("carry4", 32'(carry4), 32'(e4.carry));
                check("lat4", cyc, e4.cyc);
            end
        end
    end

    // Drive a one-cycle start and queue the expected result and done cycle.
    task automatic launch(input logic [15:0] a, input logic [4:0] s, input logic r,
                          input logic [15:0] eo, input logic ec, input bit both);
        int n;
        exp_t e;
        n = int'(s);
`ifdef SHL_ROTATE_EN
        if (r) n = int'(s[3:0]);
`endif
        @(posedge clk); #1;
        in_v   = a;
        sh_v   = s;
`ifdef SHL_ROTATE_EN
        rot_v  = r;
`endif
        start1 = 1'b1;
        start4 = both;
        e.out   = eo;
        e.carry = ec;
        e.cyc   = cyc + n + 1;
        q1.push_back(e);
        if (both) begin
            e.cyc = cyc + (n + 3) / 4 + 1;
            q4.push_back(e);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        in_v   = 16'($urandom);
        sh_v   = 5'($urandom);
    endtask

    // Wait, bounded, for all queued results to be consumed.
    task automatic drain();
        for (int i = 0; i < 200 && (q1.size() != 0 || q4.size() != 0); i++) begin
            @(posedge clk);
        end
        if (q1.size() != 0 || q4.size() != 0) begin
            check("drain_timeout", 32'(q1.size() + q4.size()), 0);
            q1.delete();
            q4.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [4:0]  rs;
        logic [16:0] rm;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out1",   32'(out1),   0);
        check("rst_carry1", 32'(carry1), 0);
        check("rst_busy1",  32'(busy1),  0);
        check("rst_done1",  32'(done1),  0);
        check("rst_out4",   32'(out4),   0);
        check("rst_busy4",  32'(busy4),  0);
        check("rst_done4",  32'(done4),  0);
        rst_n = 1'b1;

        vecs.push_back('{16'h8001, 5'd1,  1'b0, 16'h0002, 1'b1});
        vecs.push_back('{16'h00FF, 5'd4,  1'b0, 16'h0FF0, 1'b0});
        vecs.push_back('{16'h1234, 5'd0,  1'b0, 16'h1234, 1'b0});
        vecs.push_back('{16'hFFFF, 5'd20, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'hABCD, 5'd8,  1'b0, 16'hCD00, 1'b1});
        vecs.push_back('{16'h0001, 5'd16, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h8000, 5'd17, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'h4000, 5'd2,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 5'd15, 1'b0, 16'h8000, 1'b1});
        vecs.push_back('{16'hFFFF, 5'd31, 1'b0, 16'h0000, 1'b0});
`ifdef SHL_ROTATE_EN
        vecs.push_back('{16'h8001, 5'd17, 1'b1, 16'h0003, 1'b1});
        vecs.push_back('{16'h1234, 5'd16, 1'b1, 16'h1234, 1'b0});
        vecs.push_back('{16'hABCD, 5'd4,  1'b1, 16'hBCDA, 1'b0});
        vecs.push_back('{16'hABCD, 5'd8,  1'b1, 16'hCDAB, 1'b1});
`endif
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rs = 5'($urandom_range(0, 31));
            rm = model(ra, int'(rs));
            vecs.push_back('{ra, rs, 1'b0, rm[15:0], rm[16]});
        end

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].s, vecs[i].r, vecs[i].eo, vecs[i].ec, 1'b1);
            drain();
        end

        // A start while busy is ignored: one result, one done pulse.
        launch(16'hABCD, 5'd8, 1'b0, 16'hCD00, 1'b1, 1'b0);
        check("busy_in_shift", 32'(busy1), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_v   = 16'h0001;
        sh_v   = 5'd1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("hold_out",   32'(out1),   32'h0000CD00);
        check("hold_carry", 32'(carry1), 1);
        check("hold_done",  32'(done1),  0);
        check("hold_busy",  32'(busy1),  0);

        // Reset in the third SHIFT cycle aborts with no done pulse.
        launch(16'h0F0F, 5'd10, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        q1.delete();
        @(posedge clk); #1;
        check("abort_out",   32'(out1),   0);
        check("abort_carry", 32'(carry1), 0);
        check("abort_busy",  32'(busy1),  0);
        check("abort_done",  32'(done1),  0);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);

        // Normal operation after the abort.
        launch(16'h00FF, 5'd4, 1'b0, 16'h0FF0, 1'b0, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        check("final_queue", 32'(q1.size() + q4.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
